// File: rtl/tinytpu_stream_mm.sv
// -----------------------------------------------------------------------------
// tinytpu_stream_mm
// Self-sequenced N x N output-stationary matrix multiplier. Operand matrices
// A and B stream in over LANES-bit serial buses, the array computes C = A x B
// in 3N-2 cycles, and C streams out over a LANES-bit valid/ready bus.
//
// Serial format: flat vector is row-major, element 0 at the LSBs, each element
// LSB first; beat k carries flat bits [k*LANES +: LANES].
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   data_in_x  in   A-matrix serial beat (LANES bits)
//   data_in_y  in   B-matrix serial beat (LANES bits)
//   load_en    in   beat-valid for data_in_x/data_in_y
//   start      in   request computation (needs loaded=1)
//   data_out_z out  C-matrix serial beat (LANES bits), zero when not valid
//   out_valid  out  data_out_z holds a valid beat
//   out_ready  in   consumer accepts beat
//   busy       out  high while computing or draining
//   loaded     out  both operand buffers complete
//   done       out  one-cycle pulse after the last output beat is accepted
//
// Optional feature macro: TINYTPU_SIGNED_EN
//   defined   -> operands are two's complement, products sign-extended
//   undefined -> operands are unsigned, products zero-extended
// -----------------------------------------------------------------------------
module tinytpu_stream_mm #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned LANES = 2,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] data_in_x,
  input  logic [LANES-1:0] data_in_y,
  input  logic             load_en,
  input  logic             start,
  output logic [LANES-1:0] data_out_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             loaded,
  output logic             done
);

  localparam int unsigned NUM_PE    = N * N;
  localparam int unsigned IN_BITS   = NUM_PE * D_W;
  localparam int unsigned OUT_BITS  = NUM_PE * ACC_W;
  localparam int unsigned IN_BEATS  = IN_BITS / LANES;
  localparam int unsigned OUT_BEATS = OUT_BITS / LANES;
  localparam int unsigned PROD_W    = 2 * D_W;
  localparam int unsigned LC_W      = $clog2(IN_BEATS + 1);
  localparam int unsigned OI_W      = $clog2(OUT_BEATS + 1);
  localparam int unsigned T_W       = $clog2(3 * N - 1);
  localparam int unsigned T_LAST    = 3 * N - 3;

  // Elaboration-time parameter sanity checks
  if ((IN_BITS % LANES) != 0) begin : g_bad_in_lanes
    $error("LANES must divide N*N*D_W");
  end
  if ((OUT_BITS % LANES) != 0) begin : g_bad_out_lanes
    $error("LANES must divide N*N*ACC_W");
  end
  if (ACC_W < PROD_W + $clog2(N)) begin : g_bad_acc_w
    $error("ACC_W too narrow for the accumulation");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t              state;
  logic [LC_W-1:0]     load_cnt;
  logic [IN_BITS-1:0]  buf_x;
  logic [IN_BITS-1:0]  buf_y;
  logic [T_W-1:0]      t_cnt;
  logic [OI_W-1:0]     out_idx;
  logic [ACC_W-1:0]    acc     [NUM_PE];
  logic [ACC_W-1:0]    acc_nxt [NUM_PE];
  logic [OUT_BITS-1:0] c_flat;
  logic [OI_W-1:0]     out_idx_inc;

  // Single element product, extended to the accumulator width
  function automatic logic [ACC_W-1:0] mac_prod(input logic [D_W-1:0] a,
                                                input logic [D_W-1:0] b);
`ifdef TINYTPU_SIGNED_EN
    logic signed [PROD_W-1:0] p;
    p = PROD_W'($signed(a)) * PROD_W'($signed(b));
`else
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
`endif
    return ACC_W'(p);
  endfunction

  // Output-stationary array: PE(i,j) consumes k = t-i-j when 0 <= k < N
  always_comb begin
    for (int p = 0; p < int'(NUM_PE); p++) begin
      acc_nxt[p] = acc[p];
    end
    if (state == COMPUTE) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int j = 0; j < int'(N); j++) begin
          for (int k = 0; k < int'(N); k++) begin
            if (int'(t_cnt) == i + j + k) begin
              acc_nxt[i*int'(N)+j] = acc[i*int'(N)+j]
                + mac_prod(buf_x[(i*int'(N)+k)*int'(D_W) +: D_W],
                           buf_y[(k*int'(N)+j)*int'(D_W) +: D_W]);
            end
          end
        end
      end
    end
  end

  // Flattened result; uses acc_nxt so the final compute cycle feeds beat 0
  always_comb begin
    c_flat = '0;
    for (int p = 0; p < int'(NUM_PE); p++) begin
      c_flat[p*int'(ACC_W) +: ACC_W] = acc_nxt[p];
    end
  end

  assign out_idx_inc = out_idx + OI_W'(1);

  // Sequencer: load in IDLE, 3N-2 compute cycles, then handshake-driven drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      load_cnt   <= '0;
      buf_x      <= '0;
      buf_y      <= '0;
      t_cnt      <= '0;
      out_idx    <= '0;
      data_out_z <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      loaded     <= 1'b0;
      done       <= 1'b0;
      for (int p = 0; p < int'(NUM_PE); p++) begin
        acc[p] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A final beat takes priority; loaded is still 0 so start is ignored
          if (load_en && !loaded) begin
            buf_x[load_cnt*LANES +: LANES] <= data_in_x;
            buf_y[load_cnt*LANES +: LANES] <= data_in_y;
            load_cnt <= load_cnt + LC_W'(1);
            if (load_cnt == LC_W'(IN_BEATS - 1)) begin
              loaded <= 1'b1;
            end
          end else if (start && loaded) begin
            state <= COMPUTE;
            busy  <= 1'b1;
            t_cnt <= '0;
            for (int p = 0; p < int'(NUM_PE); p++) begin
              acc[p] <= '0;
            end
          end
        end

        COMPUTE: begin
          for (int p = 0; p < int'(NUM_PE); p++) begin
            acc[p] <= acc_nxt[p];
          end
          t_cnt <= t_cnt + T_W'(1);
          if (t_cnt == T_W'(T_LAST)) begin
            state      <= DRAIN;
            out_valid  <= 1'b1;
            out_idx    <= '0;
            data_out_z <= c_flat[0 +: LANES];
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_idx == OI_W'(OUT_BEATS - 1)) begin
              state      <= IDLE;
              out_valid  <= 1'b0;
              data_out_z <= '0;
              busy       <= 1'b0;
              loaded     <= 1'b0;
              load_cnt   <= '0;
              done       <= 1'b1;
            end else begin
              out_idx    <= out_idx_inc;
              data_out_z <= c_flat[out_idx_inc*LANES +: LANES];
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinytpu_stream_mm.sv
// -----------------------------------------------------------------------------
// tb_tinytpu_stream_mm
// Self-checking bench for tinytpu_stream_mm: directed cases plus randomized
// operands checked against a plain-arithmetic matrix multiply model.
// -----------------------------------------------------------------------------
module tb_tinytpu_stream_mm;

  localparam int unsigned D_W   = 8;
  localparam int unsigned N     = 2;
  localparam int unsigned LANES = 2;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned NE        = N * N;
  localparam int unsigned IN_BITS   = NE * D_W;
  localparam int unsigned OUT_BITS  = NE * ACC_W;
  localparam int          IN_BEATS  = int'(IN_BITS / LANES);
  localparam int          OUT_BEATS = int'(OUT_BITS / LANES);
  localparam int          LAT       = int'(3 * N - 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [LANES-1:0] data_in_x;
  logic [LANES-1:0] data_in_y;
  logic             load_en;
  logic             start;
  logic [LANES-1:0] data_out_z;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             loaded;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [D_W-1:0]      a_m   [NE];
  logic [D_W-1:0]      b_m   [NE];
  logic [ACC_W-1:0]    exp_c [NE];
  logic [IN_BITS-1:0]  a_flat;
  logic [IN_BITS-1:0]  b_flat;
  logic [OUT_BITS-1:0] got;
  logic [OUT_BITS-1:0] got_ref;

  tinytpu_stream_mm #(.D_W(D_W), .N(N), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_x  (data_in_x),
    .data_in_y  (data_in_y),
    .load_en    (load_en),
    .start      (start),
    .data_out_z (data_out_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .loaded     (loaded),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pack_ops();
    for (int e = 0; e < int'(NE); e++) begin
      a_flat[e*int'(D_W) +: D_W] = a_m[e];
      b_flat[e*int'(D_W) +: D_W] = b_m[e];
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^ACC_W
  task automatic model_mm();
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        int s;
        s = 0;
        for (int k = 0; k < int'(N); k++) begin
          int av;
          int bv;
`ifdef TINYTPU_SIGNED_EN
          av = int'($signed(a_m[i*int'(N)+k]));
          bv = int'($signed(b_m[k*int'(N)+j]));
`else
          av = int'(a_m[i*int'(N)+k]);
          bv = int'(b_m[k*int'(N)+j]);
`endif
          s = s + av * bv;
        end
        exp_c[i*int'(N)+j] = ACC_W'(s);
      end
    end
  endtask

  task automatic check_result(input string tag);
    for (int e = 0; e < int'(NE); e++) begin
      chk($sformatf("%s_c%0d", tag, e), 128'(got[e*int'(ACC_W) +: ACC_W]), 128'(exp_c[e]));
    end
  endtask

  // Drive beats [from, upto); beats past the buffer size carry random data
  task automatic load_range(input int from, input int upto);
    for (int k = from; k < upto; k++) begin
      @(negedge clk);
      load_en = 1'b1;
      if (k < IN_BEATS) begin
        data_in_x = a_flat[k*int'(LANES) +: LANES];
        data_in_y = b_flat[k*int'(LANES) +: LANES];
      end else begin
        data_in_x = LANES'($urandom);
        data_in_y = LANES'($urandom);
      end
    end
    @(negedge clk);
    load_en   = 1'b0;
    data_in_x = '0;
    data_in_y = '0;
  endtask

  // stall_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random
  // abort_after >= 0: assert reset once that many beats have been accepted
  task automatic run_compute(input int stall_mode, input int abort_after);
    int cyc;
    int beat;
    int guard;
    bit stalled;
    bit rdy;
    bit aborted;
    logic [LANES-1:0] held;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 128'(busy), 128'(1));
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (cyc == LAT - 1) chk("z_zero_while_invalid", 128'(data_out_z), 128'(0));
      @(negedge clk);
      cyc++;
    end
    chk("first_valid_latency", 128'(cyc), 128'(LAT));

    beat = 0;
    guard = 0;
    stalled = 1'b0;
    aborted = 1'b0;
    held = '0;
    while (beat < OUT_BEATS && guard < 4000) begin
      if (abort_after >= 0 && beat == abort_after) begin
        aborted = 1'b1;
        break;
      end
      chk("valid_in_drain", 128'(out_valid), 128'(1));
      if (stalled) chk("stall_hold", 128'(data_out_z), 128'(held));
      case (stall_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((guard % 4) == 0) || ((guard % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      if (rdy) begin
        got[beat*int'(LANES) +: LANES] = data_out_z;
        beat++;
        stalled = 1'b0;
      end else begin
        held = data_out_z;
        stalled = 1'b1;
      end
      guard++;
      @(negedge clk);
    end
    out_ready = 1'b0;

    if (aborted) begin
      rst = 1'b0;
      #1;
      chk("abort_out_valid", 128'(out_valid), 128'(0));
      chk("abort_loaded", 128'(loaded), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_z", 128'(data_out_z), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      return;
    end

    chk("beats_accepted", 128'(beat), 128'(OUT_BEATS));
    chk("done_pulse", 128'(done), 128'(1));
    chk("valid_after_last", 128'(out_valid), 128'(0));
    chk("busy_after_last", 128'(busy), 128'(0));
    chk("loaded_after_last", 128'(loaded), 128'(0));
    chk("z_after_last", 128'(data_out_z), 128'(0));
    @(negedge clk);
    chk("done_single_cycle", 128'(done), 128'(0));
    chk("no_extra_beats", 128'(out_valid), 128'(0));
  endtask

  task automatic set_basic();
    a_m = '{8'd1, 8'd2, 8'd3, 8'd4};
    b_m = '{8'd5, 8'd6, 8'd7, 8'd8};
    exp_c = '{20'd19, 20'd22, 20'd43, 20'd50};
    pack_ops();
  endtask

  initial begin
    rst       = 1'b0;
    load_en   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    data_in_x = '0;
    data_in_y = '0;
    got       = '0;
    got_ref   = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_loaded", 128'(loaded), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_z", 128'(data_out_z), 128'(0));
    rst = 1'b1;

    // Basic multiply
    set_basic();
    load_range(0, IN_BEATS);
    chk("basic_loaded", 128'(loaded), 128'(1));
    run_compute(0, -1);
    check_result("basic");
    got_ref = got;

    // Start after a partial load is ignored
    load_range(0, 10);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("early_busy", 128'(busy), 128'(0));
    chk("early_loaded", 128'(loaded), 128'(0));
    repeat (4) @(negedge clk);
    chk("early_busy_later", 128'(busy), 128'(0));
    chk("early_valid_later", 128'(out_valid), 128'(0));
    load_range(10, IN_BEATS);
    chk("early_loaded_full", 128'(loaded), 128'(1));
    run_compute(0, -1);
    check_result("early");

    // Back-pressure 1-0-0-1: identical beat stream to the no-stall run
    load_range(0, IN_BEATS);
    got = '0;
    run_compute(1, -1);
    check_result("stall");
    chk("stall_stream", 128'(got), 128'(got_ref));

    // Start coinciding with the final load beat: beat taken, start ignored
    load_range(0, IN_BEATS - 1);
    @(negedge clk);
    load_en   = 1'b1;
    start     = 1'b1;
    data_in_x = a_flat[(IN_BEATS-1)*int'(LANES) +: LANES];
    data_in_y = b_flat[(IN_BEATS-1)*int'(LANES) +: LANES];
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
    chk("lastbeat_start_loaded", 128'(loaded), 128'(1));
    chk("lastbeat_start_busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("lastbeat_start_busy2", 128'(busy), 128'(0));
    run_compute(0, -1);
    check_result("lastbeat");

    // Signed operands against identity
    a_m = '{8'hFF, 8'h02, 8'h03, 8'hFC};
    b_m = '{8'd1, 8'd0, 8'd0, 8'd1};
`ifdef TINYTPU_SIGNED_EN
    exp_c = '{20'hFFFFF, 20'd2, 20'd3, 20'hFFFFC};
`else
    exp_c = '{20'd255, 20'd2, 20'd3, 20'd252};
`endif
    pack_ops();
    load_range(0, IN_BEATS);
    run_compute(0, -1);
    check_result("signed");

    // Reset mid-drain, then a clean rerun
    set_basic();
    load_range(0, IN_BEATS);
    run_compute(0, 7);
    chk("post_abort_loaded", 128'(loaded), 128'(0));
    chk("post_abort_valid", 128'(out_valid), 128'(0));
    load_range(0, IN_BEATS);
    got = '0;
    run_compute(0, -1);
    check_result("after_abort");

    // Surplus load beats are ignored
    load_range(0, IN_BEATS + 4);
    chk("extra_loaded", 128'(loaded), 128'(1));
    run_compute(0, -1);
    check_result("extra");

    // Randomized operands with random back-pressure
    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < int'(NE); e++) begin
        a_m[e] = D_W'($urandom);
        b_m[e] = D_W'($urandom);
      end
      pack_ops();
      model_mm();
      load_range(0, IN_BEATS);
      run_compute(2, -1);
      check_result($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
